// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one bit per clock.
// Latency: done is high the cycle after the WIDTH-th RUN edge; back-to-back every WIDTH+1 cycles.
// Backpressure: none; start is accepted only in IDLE or DONE and is ignored while busy.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             sbit,
  output logic             sbit_valid
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             sbit_q, sbit_d;
  logic             sbit_valid_q, sbit_valid_d;

  // Full-subtractor cell on the current LSBs and the assembled result after this bit.
  logic             bit_d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  // Next-state logic: operand capture, serial borrow chain and result registration.
  always_comb begin
    bit_d        = ra_q[0] ^ rb_q[0] ^ br_q;
    br_nxt       = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
    res_nxt      = {bit_d, res_q[WIDTH-1:1]};

    state_d      = state_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    res_d        = res_q;
    cnt_d        = cnt_q;
    br_d         = br_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    ovf_d        = ovf_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    sbit_d       = 1'b0;
    sbit_valid_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // DONE accepts exactly like IDLE so operations can run back-to-back.
          ra_d    = a;
          rb_d    = b;
          res_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        ra_d         = ra_q >> 1;
        rb_d         = rb_q >> 1;
        res_d        = res_nxt;
        br_d         = br_nxt;
        cnt_d        = cnt_q + CW'(1);
        sbit_d       = bit_d;
        sbit_valid_d = 1'b1;
        if (cnt_q == LAST) begin
          // Parallel results change only here, so they stay stable through a following RUN.
          state_d  = S_DONE;
          done_d   = 1'b1;
          diff_d   = res_nxt;
          borrow_d = br_nxt;
          // Overflow needs operands of opposite sign and a result whose sign differs from a.
          ovf_d    = (a_msb_q != b_msb_q) & (res_nxt[WIDTH-1] != a_msb_q);
        end else begin
          busy_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ra_q         <= '0;
      rb_q         <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
      br_q         <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      ovf_q        <= 1'b0;
      sbit_q       <= 1'b0;
      sbit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      br_q         <= br_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      ovf_q        <= ovf_d;
      sbit_q       <= sbit_d;
      sbit_valid_q <= sbit_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow     = borrow_q;
  assign ovf        = ovf_q;
  assign sbit       = sbit_q;
  assign sbit_valid = sbit_valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, monitor pops on done.
// Expected values come from integer arithmetic on the operands, not from the datapath.
// Checks results, serial tap, done timing, spurious/missing done and reset clearing.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         sbit;
  logic         sbit_valid;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow     (borrow),
    .ovf        (ovf),
    .sbit       (sbit),
    .sbit_valid (sbit_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    int           done_edge;
  } exp_t;

  exp_t         expq[$];
  exp_t         mon_e;
  int           vectors    = 0;
  int           miscompares = 0;
  int           edge_cnt   = 0;
  int           run_left   = 0;
  logic [W-1:0] sbits      = '0;
  int           nsb        = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Reference: plain integer subtraction and signed-range test.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int de);
    exp_t m;
    int   ia;
    int   ib;
    int   sa;
    int   sb;
    int   r;
    ia = int'(x);
    ib = int'(y);
    sa = (ia >= 2**(W-1)) ? ia - 2**W : ia;
    sb = (ib >= 2**(W-1)) ? ib - 2**W : ib;
    r  = sa - sb;
    m.diff      = W'(ia - ib);
    m.borrow    = (ia < ib);
    m.ovf       = (r < -(2**(W-1))) || (r > 2**(W-1) - 1);
    m.done_edge = de;
    return m;
  endfunction

  // Protocol model: an operation occupies W edges after acceptance; otherwise start is taken.
  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      run_left = 0;
      expq.delete();
    end else if (run_left == 0) begin
      if (start) begin
        expq.push_back(model(a, b, edge_cnt + W));
        run_left = W;
      end
    end else begin
      run_left--;
    end
  end

  // Monitor: collect the serial tap and check each done against the scoreboard head.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      nsb = 0;
    end else begin
      if (sbit_valid) begin
        sbits = {sbit, sbits[W-1:1]};
        nsb++;
      end
      if (done) begin
        if (expq.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = expq.pop_front();
          chk("diff",      32'(diff),     32'(mon_e.diff));
          chk("borrow",    32'(borrow),   32'(mon_e.borrow));
          chk("ovf",       32'(ovf),      32'(mon_e.ovf));
          chk("sbit_seq",  32'(sbits),    32'(mon_e.diff));
          chk("sbit_cnt",  32'(nsb),      32'(W));
          chk("done_edge", 32'(edge_cnt), 32'(mon_e.done_edge));
        end
        nsb = 0;
      end else if (expq.size() > 0 && edge_cnt > expq[0].done_edge) begin
        chk("missing_done", 32'd0, 32'd1);
        void'(expq.pop_front());
      end
    end
  end

  task automatic cyc(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = s;
    a     = x;
    b     = y;
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
    cyc(1'b1, x, y);
    repeat (W + 1) cyc(1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_done"},       32'(done),       32'd0);
    chk({tag, "_diff"},       32'(diff),       32'd0);
    chk({tag, "_borrow"},     32'(borrow),     32'd0);
    chk({tag, "_ovf"},        32'(ovf),        32'd0);
    chk({tag, "_sbit"},       32'(sbit),       32'd0);
    chk({tag, "_sbit_valid"}, 32'(sbit_valid), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed operand pairs, including both signed-overflow directions.
    op(4'd5, 4'd3);
    op(4'd3, 4'd5);
    op(4'd7, 4'd8);
    op(4'd8, 4'd1);

    // start held high: mid-RUN start/operand changes ignored, second op taken in DONE.
    cyc(1'b1, 4'd5, 4'd3);
    repeat (W) cyc(1'b1, W'($urandom), W'($urandom));
    cyc(1'b1, 4'd3, 4'd5);
    repeat (W) cyc(1'b1, W'($urandom), W'($urandom));
    repeat (W + 2) cyc(1'b0, W'($urandom), W'($urandom));

    // Reset on the second RUN cycle discards the operation.
    cyc(1'b1, 4'd5, 4'd3);
    cyc(1'b0, 4'd0, 4'd0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk_zero("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) cyc(1'b0, 4'd0, 4'd0);
    op(4'd9, 4'd9);
    op(4'd0, 4'd0);
    op(4'hF, 4'hF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
    end

    // Drain with a bounded wait.
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4 * W && expq.size() > 0; i++) @(negedge clk);
    chk("drain_empty", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
